// File: rtl/ledmt_pkg.sv
// Shared types and sizing helpers for the LED matrix BCM scan controller.
package ledmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SHOW,
    WAIT_DATA,
    DRAIN,
    BLANK
  } scan_state_e;

  localparam int DEF_ROWS        = 8;
  localparam int DEF_COLS        = 8;
  localparam int DEF_BITS        = 8;
  localparam int DEF_BASE_TICKS  = 4;
  localparam int DEF_BLANK_TICKS = 2;

  // Wide enough for BASE_TICKS << (bits-1) without overflow.
  function automatic int weight_width(input int base_ticks, input int bits);
    return $clog2(base_ticks) + bits;
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcm_timer.sv
// Binary-weighted display timer: loads BASE_TICKS << plane, counts down while run is high,
// and flags the final display cycle.
module bcm_timer
  import ledmt_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  localparam int TW = weight_width(BASE_TICKS, BITS),
  localparam int PW = addr_width(BITS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          run,
  input  logic [PW-1:0] plane,
  output logic          last
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(BASE_TICKS) << plane;
    end else if (run && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == TW'(1));

endmodule

// File: rtl/bcm_scan_ctrl.sv
// Row/bit-plane BCM scan scheduler: prefetches each plane word and lights it for BASE_TICKS << plane.
// Define LEDMT_GHOST_BLANK_EN to add a BLANK_TICKS dark period (row_sel switch) before each latch.
module bcm_scan_ctrl
  import ledmt_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int BITS        = DEF_BITS,
  parameter int BASE_TICKS  = DEF_BASE_TICKS,
  parameter int BLANK_TICKS = DEF_BLANK_TICKS,
  localparam int RW = addr_width(ROWS),
  localparam int PW = addr_width(BITS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  output logic            rd_req,
  output logic [RW-1:0]   rd_row,
  output logic [PW-1:0]   rd_plane,
  input  logic            rd_valid,
  input  logic [COLS-1:0] rd_data,
  output logic [COLS-1:0] col_data,
  output logic [RW-1:0]   row_sel,
  output logic            latch,
  output logic            oe,
  output logic            frame_done,
  output logic            underrun
);

  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(BITS - 1);

  scan_state_e     state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [RW-1:0]   row_sel_q, row_sel_d;
  logic [COLS-1:0] shadow_q, shadow_d;
  logic [COLS-1:0] col_q, col_d;
  logic            req_q, req_d;
  logic            full_q, full_d;
  logic            last_pair_q, last_pair_d;
  logic            accept;
  logic            timer_load;
  logic            timer_run;
  logic            timer_last;

`ifdef LEDMT_GHOST_BLANK_EN
  localparam int BW = addr_width(BLANK_TICKS);
  logic [BW-1:0] blank_q, blank_d;
`endif

  assign accept    = req_q & rd_valid;
  assign timer_run = (state_q == SHOW);

  bcm_timer #(
    .BITS       (BITS),
    .BASE_TICKS (BASE_TICKS)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .run   (timer_run),
    .plane (plane_q),
    .last  (timer_last)
  );

  // row/plane pointers always address the next pair to fetch; LATCH consumes them and advances.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    plane_d     = plane_q;
    row_sel_d   = row_sel_q;
    shadow_d    = shadow_q;
    col_d       = col_q;
    req_d       = req_q & ~accept;
    full_d      = full_q;
    last_pair_d = last_pair_q;
`ifdef LEDMT_GHOST_BLANK_EN
    blank_d     = blank_q;
`endif
    latch       = 1'b0;
    oe          = 1'b0;
    frame_done  = 1'b0;
    underrun    = 1'b0;
    timer_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          row_d   = '0;
          plane_d = '0;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (accept) begin
          shadow_d = rd_data;
          full_d   = 1'b1;
          state_d  = LATCH;
        end
      end

      LATCH: begin
        latch       = 1'b1;
        col_d       = shadow_q;
`ifndef LEDMT_GHOST_BLANK_EN
        row_sel_d   = row_q;
`endif
        timer_load  = 1'b1;
        full_d      = 1'b0;
        last_pair_d = (row_q == LAST_ROW) && (plane_q == LAST_PLANE);
        if (plane_q == LAST_PLANE) begin
          plane_d = '0;
          row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end else begin
          plane_d = plane_q + 1'b1;
        end
        req_d   = 1'b1;
        state_d = SHOW;
      end

      SHOW: begin
        oe = 1'b1;
        if (accept) begin
          shadow_d = rd_data;
          full_d   = 1'b1;
        end
        if (timer_last) begin
          frame_done = last_pair_q;
          if (!enable) begin
            state_d = DRAIN;
          end else if (full_q || accept) begin
`ifdef LEDMT_GHOST_BLANK_EN
            row_sel_d = row_q;
            blank_d   = BW'(BLANK_TICKS - 1);
            state_d   = BLANK;
`else
            state_d   = LATCH;
`endif
          end else begin
            underrun = 1'b1;
            state_d  = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        if (accept) begin
          shadow_d = rd_data;
          full_d   = 1'b1;
`ifdef LEDMT_GHOST_BLANK_EN
          row_sel_d = row_q;
          blank_d   = BW'(BLANK_TICKS - 1);
          state_d   = BLANK;
`else
          state_d   = LATCH;
`endif
        end
      end

      // Any outstanding prefetch must complete before the frame store is released.
      DRAIN: begin
        if (!req_q || accept) begin
          full_d    = 1'b0;
          col_d     = '0;
          row_sel_d = '0;
          row_d     = '0;
          plane_d   = '0;
          state_d   = IDLE;
        end
      end

`ifdef LEDMT_GHOST_BLANK_EN
      BLANK: begin
        if (blank_q == '0) begin
          state_d = LATCH;
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      plane_q     <= '0;
      row_sel_q   <= '0;
      shadow_q    <= '0;
      col_q       <= '0;
      req_q       <= 1'b0;
      full_q      <= 1'b0;
      last_pair_q <= 1'b0;
`ifdef LEDMT_GHOST_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      row_sel_q   <= row_sel_d;
      shadow_q    <= shadow_d;
      col_q       <= col_d;
      req_q       <= req_d;
      full_q      <= full_d;
      last_pair_q <= last_pair_d;
`ifdef LEDMT_GHOST_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  assign rd_req   = req_q;
  assign rd_row   = row_q;
  assign rd_plane = plane_q;
  assign col_data = col_q;
  assign row_sel  = row_sel_q;

endmodule

// File: tb/tb_bcm_scan_ctrl.sv
// Directed bench for bcm_scan_ctrl (ROWS=2, BITS=3, BASE_TICKS=4) with a frame-store responder.
module tb_bcm_scan_ctrl;
  import ledmt_pkg::*;

  localparam int ROWS  = 2;
  localparam int COLS  = 8;
  localparam int BITS  = 3;
  localparam int BASE  = 4;
  localparam int BLANK_T = 2;
`ifdef LEDMT_GHOST_BLANK_EN
  localparam int GAP   = BLANK_T + 1;
  localparam bit GHOST = 1'b1;
`else
  localparam int GAP   = 1;
  localparam bit GHOST = 1'b0;
`endif
  localparam int SLOW1 = 10;
  localparam int SLOW2 = 30;
  localparam int RW = addr_width(ROWS);
  localparam int PW = addr_width(BITS);

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic            rd_req;
  logic [RW-1:0]   rd_row;
  logic [PW-1:0]   rd_plane;
  logic            rd_valid;
  logic [COLS-1:0] rd_data;
  logic [COLS-1:0] col_data;
  logic [RW-1:0]   row_sel;
  logic            latch;
  logic            oe;
  logic            frame_done;
  logic            underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int ur_cnt = 0;
  int last_fd_cyc = -1;
  int fd_times[$];
  int addr_log[$];

  bit slow_armed = 1'b0;
  int slow_row, slow_plane, slow_delay;

  int r, p, prev_r, prev_p, hi, lo, n, fd0, ur0;

  bcm_scan_ctrl #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .BITS        (BITS),
    .BASE_TICKS  (BASE),
    .BLANK_TICKS (BLANK_T)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rd_req     (rd_req),
    .rd_row     (rd_row),
    .rd_plane   (rd_plane),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .col_data   (col_data),
    .row_sel    (row_sel),
    .latch      (latch),
    .oe         (oe),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pat(input int rr, input int pp);
    return 8'(8'h80 + rr * 16 + pp);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(negedge clock);
    cyc++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      last_fd_cyc = cyc;
      fd_times.push_back(cyc);
    end
    if (underrun === 1'b1) ur_cnt++;
  endtask

  task automatic wait_latch(input int limit);
    int k;
    k = 0;
    while (latch !== 1'b1 && k < limit) begin
      step_cycle();
      k++;
    end
    check_output("latch_seen", latch, 1);
  endtask

  task automatic arm_slow(input int rr, input int pp, input int dly);
    slow_row   = rr;
    slow_plane = pp;
    slow_delay = dly;
    slow_armed = 1'b1;
  endtask

  // Frame-store model: answers each request after 1 cycle, or after slow_delay for the armed address.
  initial begin
    bit busy;
    int wait_cnt, this_delay;
    busy = 1'b0;
    wait_cnt = 0;
    this_delay = 1;
    rd_valid = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset === 1'b1) begin
        rd_valid = 1'b0;
        busy = 1'b0;
      end else if (rd_valid) begin
        rd_valid = 1'b0;
        busy = 1'b0;
      end else if (rd_req === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          wait_cnt = 0;
          this_delay = 1;
          if (slow_armed && int'(rd_row) == slow_row && int'(rd_plane) == slow_plane) begin
            this_delay = slow_delay;
            slow_armed = 1'b0;
          end
        end
        if (wait_cnt >= this_delay) begin
          rd_valid = 1'b1;
          rd_data = pat(int'(rd_row), int'(rd_plane));
          addr_log.push_back(int'(rd_row) * 8 + int'(rd_plane));
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) step_cycle();
    check_output("rst_oe", oe, 0);
    check_output("rst_latch", latch, 0);
    check_output("rst_rd_req", rd_req, 0);
    check_output("rst_col_data", col_data, 0);
    check_output("rst_row_sel", row_sel, 0);
    check_output("rst_rd_row", rd_row, 0);
    check_output("rst_rd_plane", rd_plane, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("rst_underrun", underrun, 0);
    reset = 1'b0;
    repeat (2) step_cycle();
    check_output("idle_no_req", rd_req, 0);

    enable = 1'b1;
    wait_latch(20);
    prev_r = 0;
    prev_p = 0;
    for (int i = 0; i < 20; i++) begin
      r = (i / BITS) % ROWS;
      p = i % BITS;
      if (i == 12) arm_slow(0, 1, SLOW1);
      check_output("oe_at_latch", oe, 0);
      if (i > 0) begin
        check_output("col_hold_at_latch", col_data, pat(prev_r, prev_p));
        check_output("row_sel_at_latch", row_sel, GHOST ? r : prev_r);
      end
      step_cycle();
      check_output("col_data", col_data, pat(r, p));
      check_output("row_sel", row_sel, r);
      fd0 = fd_cnt;
      ur0 = ur_cnt;
      hi = 0;
      while (oe === 1'b1 && hi < 100) begin
        hi++;
        step_cycle();
      end
      check_output("oe_width", hi, BASE << p);
      check_output("frame_done_pulses", fd_cnt - fd0, (r == ROWS - 1 && p == BITS - 1) ? 1 : 0);
      if (r == ROWS - 1 && p == BITS - 1) check_output("frame_done_pos", last_fd_cyc, cyc - 1);
      check_output("underrun_pulses", ur_cnt - ur0, (i == 12) ? 1 : 0);
      lo = 1;
      while (latch !== 1'b1 && lo < 100) begin
        step_cycle();
        lo++;
      end
      check_output("dark_gap", lo, (i == 12) ? (SLOW1 - 2 + GAP - 1) : GAP);
      prev_r = r;
      prev_p = p;
    end

    check_output("frame_count", (fd_times.size() >= 2) ? 1 : 0, 1);
    if (fd_times.size() >= 2)
      check_output("frame_period", fd_times[1] - fd_times[0], ROWS * (BASE * ((1 << BITS) - 1) + BITS * GAP));
    check_output("addr_log_len", (addr_log.size() >= 13) ? 1 : 0, 1);
    for (int k = 0; k < 13 && k < addr_log.size(); k++)
      check_output("addr_seq", addr_log[k], ((k / BITS) % ROWS) * 8 + (k % BITS));

    // Enable drop during plane 2 of row 0 with the next fetch held off.
    arm_slow(1, 0, SLOW2);
    check_output("drop_oe_at_latch", oe, 0);
    step_cycle();
    check_output("drop_col_data", col_data, pat(0, 2));
    ur0 = ur_cnt;
    hi = 0;
    while (oe === 1'b1 && hi < 100) begin
      hi++;
      if (hi == 5) enable = 1'b0;
      step_cycle();
    end
    check_output("drop_oe_width", hi, BASE << 2);
    check_output("drain_req_held", rd_req, 1);
    check_output("drain_no_latch", latch, 0);
    n = 0;
    while (rd_req === 1'b1 && n < 100) begin
      step_cycle();
      n++;
    end
    check_output("drain_len", n, SLOW2 + 1 - (BASE << 2));
    check_output("drain_no_underrun", ur_cnt - ur0, 0);
    check_output("idle_oe", oe, 0);
    check_output("idle_latch", latch, 0);
    check_output("idle_col_data", col_data, 0);
    check_output("idle_row_sel", row_sel, 0);
    check_output("idle_rd_row", rd_row, 0);
    check_output("idle_rd_plane", rd_plane, 0);
    check_output("idle_frame_done", frame_done, 0);
    repeat (3) step_cycle();
    check_output("idle_stays", rd_req, 0);

    // Reset in the middle of a SHOW, then restart.
    enable = 1'b1;
    wait_latch(20);
    repeat (3) step_cycle();
    check_output("show_before_reset", oe, 1);
    reset = 1'b1;
    step_cycle();
    check_output("midrst_oe", oe, 0);
    check_output("midrst_rd_req", rd_req, 0);
    check_output("midrst_latch", latch, 0);
    check_output("midrst_col_data", col_data, 0);
    reset = 1'b0;
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      step_cycle();
      n++;
    end
    check_output("restart_req", rd_req, 1);
    check_output("restart_row", rd_row, 0);
    check_output("restart_plane", rd_plane, 0);
    wait_latch(20);
    step_cycle();
    check_output("restart_col_data", col_data, pat(0, 0));
    check_output("restart_row_sel", row_sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcm_scan_ctrl.md
Name: bcm_scan_ctrl

Overview:
- Row/bit-plane scheduler for the LED matrix driver.
- Walks every (row, plane) pair of a frame.
- Fetches each plane's column word from the frame store through a req/valid handshake, prefetching during display.
- Latches the word to the column drivers and gates output-enable for a binary-weighted time (BASE_TICKS << plane).
- Sits between the frame-store read port and the column/row driver pins.

Parameters:
ROWS, 8, number of scanned rows
COLS, 8, column word width
BITS, 8, bit planes per pixel (plane 0 = LSB)
BASE_TICKS, 4, display cycles for plane 0
BLANK_TICKS, 2, pre-latch blank cycles (used only with the optional feature)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  run scan when high
rd_req  out  1  frame-store read request
rd_row  out  clog2(ROWS)  row address of request
rd_plane  out  clog2(BITS)  plane address of request
rd_valid  in  1  read data valid (ignored while rd_req low)
rd_data  in  COLS  read data
col_data  out  COLS  column driver word
row_sel  out  clog2(ROWS)  active row address
latch  out  1  one-cycle column latch strobe
oe  out  1  output enable, active high = LEDs lit
frame_done  out  1  one-cycle pulse at end of frame
underrun  out  1  one-cycle pulse when a plane's data was late

Behaviour:
- Reset values: all outputs 0, state IDLE, row/plane pointers 0, shadow empty.
- Reset mid-operation drops rd_req immediately. The frame store tolerates the abort.
- Handshake:
  - rd_req rises with rd_row/rd_plane; address holds stable until rd_valid is sampled high with rd_req high.
  - rd_req deasserts the cycle after that acceptance.
  - rd_data is captured into the shadow register on acceptance.
- Scan order: plane inner (0..BITS-1), row outer (0..ROWS-1). Pointers wrap to (0,0) after (ROWS-1, BITS-1).
- IDLE: oe=0, rd_req=0. When enable=1: pointers = (0,0), rd_req=1, go to FETCH.
- FETCH: on acceptance go to LATCH.
- LATCH (exactly one cycle):
  - col_data <= shadow; row_sel <= row; latch=1; oe=0.
  - Timer loads BASE_TICKS << plane.
  - Pointers advance; rd_req for the next pair asserts this cycle (prefetch).
  - Go to SHOW.
- SHOW:
  - oe=1; timer decrements each cycle; prefetch acceptance may occur in any cycle.
  - On the last display cycle (timer==1):
    - If this pair was (ROWS-1, BITS-1), pulse frame_done.
    - If enable=0, go to DRAIN.
    - Else if the shadow is full, go to LATCH.
    - Else pulse underrun and go to WAIT_DATA.
  - Prefetch acceptance on the same cycle as timer==1 counts as shadow full.
- WAIT_DATA: oe=0; on acceptance go to LATCH.
- DRAIN: oe=0. If rd_req is outstanding, wait for rd_valid and discard the data. Then go to IDLE.
- Timing guarantees:
  - oe is low for exactly 1 cycle between planes when the prefetch is on time.
  - Displayed width of plane b = BASE_TICKS·2^b cycles exactly.
- Timer width: clog2(BASE_TICKS) + BITS. No overflow at plane BITS-1.

Optional Feature:
- LEDMT_GHOST_BLANK_EN defined:
  - A BLANK state of BLANK_TICKS cycles (oe=0) sits between SHOW and LATCH, and WAIT_DATA exits through it.
  - row_sel updates at BLANK entry; col_data updates in LATCH.
  - Inter-plane dark gap = BLANK_TICKS+1.
- Undefined: no BLANK state; behaviour as above.

Decomposition:
- Shared package ledmt_pkg holds:
  - the state enum (IDLE, FETCH, LATCH, SHOW, WAIT_DATA, DRAIN, BLANK);
  - default parameter constants;
  - a function for the weight width.
- One sub-module, bcm_timer: loads BASE_TICKS << plane, counts down, flags last cycle.

Test Plan:
- Plane timing: ROWS=2, BITS=3, BASE_TICKS=4, rd_valid the cycle after every rd_req -> oe high runs of 4, 8, 16 cycles per row, each separated by exactly one oe-low latch cycle; no underrun.
- Frame wrap: run 2 frames with the same config -> frame_done pulses once per 2·(4+8+16+3) = 62 cycles; rd_row/rd_plane sequence (0,0)(0,1)(0,2)(1,0)…; wraps to (0,0).
- Underrun: delay rd_valid 10 cycles for plane 0 prefetch -> one underrun pulse; oe low until acceptance; next LATCH carries the delayed rd_data; plane 1 still shows 8 cycles.
- Enable drop: deassert enable mid-SHOW of plane 2 with rd_req outstanding -> plane finishes its 16 cycles; rd_req held until rd_valid; state returns to IDLE; all outputs 0.
- Reset mid-SHOW: assert reset for 1 cycle -> next cycle oe, rd_req, latch, col_data all 0; after reset, enable restarts at (0,0).
- LEDMT_GHOST_BLANK_EN with BLANK_TICKS=2 -> inter-plane oe-low gap of 3 cycles; row_sel changes 2 cycles before latch.
